// File: rtl/gate_boy_pkg.sv
// Shared Game Boy CPU types: register selectors, flag bit positions, M-cycle timing
// and the register-file state record with its read helpers.
package gate_boy_pkg;

    localparam int DATA_WIDTH         = 8;
    localparam int TCYCLES_PER_MCYCLE = 4;
    localparam logic [1:0] LAST_TCYCLE = 2'(TCYCLES_PER_MCYCLE - 1);

    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

    typedef enum logic [3:0] {
        R8_B, R8_C, R8_D, R8_E, R8_H, R8_L, R8_A, R8_F, R8_W, R8_Z
    } reg8_sel_t;

    typedef enum logic [2:0] {
        R16_BC, R16_DE, R16_HL, R16_SP, R16_PC, R16_AF, R16_WZ
    } reg16_sel_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a, f, b, c, d, e, h, l, w, z;
        logic [15:0]           sp, pc;
    } reg_state_t;

    // F's low nibble does not exist architecturally, so every read masks it.
    function automatic logic [7:0] read8(input reg_state_t s, input reg8_sel_t sel);
        logic [7:0] v;
        v = '0;
        case (sel)
            R8_B: v = s.b;
            R8_C: v = s.c;
            R8_D: v = s.d;
            R8_E: v = s.e;
            R8_H: v = s.h;
            R8_L: v = s.l;
            R8_A: v = s.a;
            R8_F: v = {s.f[FLAG_Z:FLAG_C], 4'h0};
            R8_W: v = s.w;
            R8_Z: v = s.z;
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [15:0] read16(input reg_state_t s, input reg16_sel_t sel);
        logic [15:0] v;
        v = '0;
        case (sel)
            R16_BC: v = {s.b, s.c};
            R16_DE: v = {s.d, s.e};
            R16_HL: v = {s.h, s.l};
            R16_SP: v = s.sp;
            R16_PC: v = s.pc;
            R16_AF: v = {s.a, s.f[FLAG_Z:FLAG_C], 4'h0};
            R16_WZ: v = {s.w, s.z};
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/reg_file_tcycle_ctr.sv
// T-cycle phase counter: advances 0..3 while cpu_en is high, freezes otherwise,
// and flags the last T-cycle of an enabled M-cycle as the commit slot.
module tcycle_ctr
    import gate_boy_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_en,
    output logic [1:0] tcycle,
    output logic       commit
);

    logic [1:0] tcycle_q;
    logic [1:0] tcycle_d;

    always_comb begin
        tcycle_d = tcycle_q;
        if (cpu_en) tcycle_d = tcycle_q + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcycle_q <= 2'd0;
        else        tcycle_q <= tcycle_d;
    end

    assign tcycle = tcycle_q;
    assign commit = (tcycle_q == LAST_TCYCLE) && cpu_en;

endmodule

// File: rtl/reg_file.sv
// Game Boy CPU register file with M-cycle-aligned commits and a latched address bus.
// Define REGFILE_BYPASS_EN to forward the committing value onto the read ports.
module reg_file
    import gate_boy_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] RESET_SP = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_en,
    output logic [1:0]  tcycle,
    output logic        commit,
    input  reg16_sel_t  rd16_sel,
    output logic [15:0] rd16_data,
    input  reg8_sel_t   rd8_sel,
    output logic [7:0]  rd8_data,
    input  reg16_sel_t  addr_sel,
    output logic [15:0] addr,
    input  logic        wr16_en,
    input  reg16_sel_t  wr16_sel,
    input  logic [15:0] wr16_data,
    input  logic        wr8_en,
    input  reg8_sel_t   wr8_sel,
    input  logic [7:0]  wr8_data,
    input  logic [3:0]  flag_we,
    input  logic [3:0]  flag_in
);

    reg_state_t  state_q;
    reg_state_t  state_d;
    reg_state_t  read_view;
    logic [15:0] addr_q;

    tcycle_ctr u_tcycle_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .cpu_en (cpu_en),
        .tcycle (tcycle),
        .commit (commit)
    );

    // Applied lowest precedence first so later writes override per byte: flags, wr16, wr8.
    always_comb begin
        state_d = state_q;
        if (commit) begin
            state_d.f[FLAG_Z:FLAG_C] = (state_q.f[FLAG_Z:FLAG_C] & ~flag_we) | (flag_in & flag_we);
            if (wr16_en) begin
                case (wr16_sel)
                    R16_BC: {state_d.b, state_d.c} = wr16_data;
                    R16_DE: {state_d.d, state_d.e} = wr16_data;
                    R16_HL: {state_d.h, state_d.l} = wr16_data;
                    R16_SP: state_d.sp = wr16_data;
                    R16_PC: state_d.pc = wr16_data;
                    R16_AF: {state_d.a, state_d.f} = wr16_data;
                    R16_WZ: {state_d.w, state_d.z} = wr16_data;
                    default: ;
                endcase
            end
            if (wr8_en) begin
                case (wr8_sel)
                    R8_B: state_d.b = wr8_data;
                    R8_C: state_d.c = wr8_data;
                    R8_D: state_d.d = wr8_data;
                    R8_E: state_d.e = wr8_data;
                    R8_H: state_d.h = wr8_data;
                    R8_L: state_d.l = wr8_data;
                    R8_A: state_d.a = wr8_data;
                    R8_F: state_d.f = wr8_data;
                    R8_W: state_d.w = wr8_data;
                    R8_Z: state_d.z = wr8_data;
                    default: ;
                endcase
            end
            state_d.f[3:0] = 4'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= '0;
            state_q.pc <= RESET_PC;
            state_q.sp <= RESET_SP;
            addr_q     <= RESET_PC;
        end else begin
            state_q <= state_d;
            // Capture at the edge leaving T0; no commit can coincide, so this is pre-commit state.
            if (cpu_en && (tcycle == 2'd0)) addr_q <= read16(state_q, addr_sel);
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign read_view = state_d;
`else
    assign read_view = state_q;
`endif

    assign rd16_data = read16(read_view, rd16_sel);
    assign rd8_data  = read8(read_view, rd8_sel);
    assign addr      = addr_q;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: reset/counter checks, a table of M-cycle write vectors,
// and hand sequences for stalls, address latching, bypass visibility and mid-cycle reset.
module tb_reg_file;
    import gate_boy_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        cpu_en;
    logic [1:0]  tcycle;
    logic        commit;
    reg16_sel_t  rd16_sel;
    logic [15:0] rd16_data;
    reg8_sel_t   rd8_sel;
    logic [7:0]  rd8_data;
    reg16_sel_t  addr_sel;
    logic [15:0] addr;
    logic        wr16_en;
    reg16_sel_t  wr16_sel;
    logic [15:0] wr16_data;
    logic        wr8_en;
    reg8_sel_t   wr8_sel;
    logic [7:0]  wr8_data;
    logic [3:0]  flag_we;
    logic [3:0]  flag_in;

    reg_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_en    (cpu_en),
        .tcycle    (tcycle),
        .commit    (commit),
        .rd16_sel  (rd16_sel),
        .rd16_data (rd16_data),
        .rd8_sel   (rd8_sel),
        .rd8_data  (rd8_data),
        .addr_sel  (addr_sel),
        .addr      (addr),
        .wr16_en   (wr16_en),
        .wr16_sel  (wr16_sel),
        .wr16_data (wr16_data),
        .wr8_en    (wr8_en),
        .wr8_sel   (wr8_sel),
        .wr8_data  (wr8_data),
        .flag_we   (flag_we),
        .flag_in   (flag_in)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard
    logic [15:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic push_exp(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act);
        logic [15:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got %h, no expected value queued", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", name, act, exp);
            end
        end
    endtask

    // Drivers
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_req();
        wr16_en   = 1'b0;
        wr16_sel  = R16_BC;
        wr16_data = '0;
        wr8_en    = 1'b0;
        wr8_sel   = R8_B;
        wr8_data  = '0;
        flag_we   = '0;
        flag_in   = '0;
    endtask

    typedef struct {
        logic        w16_en;
        reg16_sel_t  w16_sel;
        logic [15:0] w16_data;
        logic        w8_en;
        reg8_sel_t   w8_sel;
        logic [7:0]  w8_data;
        logic [3:0]  fwe;
        logic [3:0]  fin;
        reg16_sel_t  r16_sel;
        reg8_sel_t   r8_sel;
        logic [15:0] exp_addr;
        logic [15:0] exp16;
        logic [7:0]  exp8;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1, R16_PC, 16'h0100, 0, R8_B, 8'h00, 4'h0, 4'h0, R16_PC, R8_A, 16'h0000, 16'h0100, 8'h00};
        vecs[1]  = '{1, R16_HL, 16'h1234, 1, R8_L, 8'hAB, 4'h0, 4'h0, R16_HL, R8_H, 16'h0100, 16'h12AB, 8'h12};
        vecs[2]  = '{0, R16_BC, 16'h0000, 1, R8_F, 8'hFF, 4'h0, 4'h0, R16_AF, R8_F, 16'h0100, 16'h00F0, 8'hF0};
        vecs[3]  = '{0, R16_BC, 16'h0000, 0, R8_B, 8'h00, 4'b0100, 4'b0000, R16_AF, R8_F, 16'h0100, 16'h00B0, 8'hB0};
        vecs[4]  = '{1, R16_AF, 16'h5A3C, 0, R8_B, 8'h00, 4'b1111, 4'b0000, R16_AF, R8_A, 16'h0100, 16'h5A30, 8'h5A};
        vecs[5]  = '{1, R16_BC, 16'hFFFF, 1, R8_B, 8'h01, 4'h0, 4'h0, R16_BC, R8_C, 16'h0100, 16'h01FF, 8'hFF};
        vecs[6]  = '{1, R16_SP, 16'hFFFF, 0, R8_B, 8'h00, 4'h0, 4'h0, R16_SP, R8_B, 16'h0100, 16'hFFFF, 8'h01};
        vecs[7]  = '{0, R16_BC, 16'h0000, 1, R8_F, 8'h00, 4'b1111, 4'b1111, R16_AF, R8_F, 16'h0100, 16'h5A00, 8'h00};
        vecs[8]  = '{0, R16_BC, 16'h0000, 0, R8_B, 8'h00, 4'b1001, 4'b1111, R16_AF, R8_F, 16'h0100, 16'h5A90, 8'h90};
        vecs[9]  = '{1, R16_WZ, 16'hBEEF, 1, R8_Z, 8'h11, 4'h0, 4'h0, R16_WZ, R8_W, 16'h0100, 16'hBE11, 8'hBE};
        vecs[10] = '{1, R16_DE, 16'hCAFE, 0, R8_B, 8'h00, 4'h0, 4'h0, R16_DE, R8_E, 16'h0100, 16'hCAFE, 8'hFE};
    end

    initial begin
        rst_n    = 1'b0;
        cpu_en   = 1'b0;
        rd16_sel = R16_PC;
        rd8_sel  = R8_A;
        addr_sel = R16_PC;
        clear_req();
        tick(2);

        // Reset state
        push_exp(16'd0); check("reset_tcycle", {14'd0, tcycle});
        push_exp(16'd0); check("reset_commit", {15'd0, commit});
        push_exp(16'h0000); check("reset_addr", addr);
        push_exp(16'h0000); check("reset_pc", rd16_data);
        for (int i = 0; i < 10; i++) begin
            rd8_sel = reg8_sel_t'(i);
            #1;
            push_exp(16'h0000); check("reset_rd8", {8'h00, rd8_data});
        end

        rst_n  = 1'b1;
        cpu_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push_exp(16'(k % 4)); check("run_tcycle", {14'd0, tcycle});
            push_exp({15'd0, (k % 4) == 3}); check("run_commit", {15'd0, commit});
            tick(1);
        end

        // Table-driven M-cycles, each starting at T0
        for (int v = 0; v < 11; v++) begin
            wr16_en   = vecs[v].w16_en;
            wr16_sel  = vecs[v].w16_sel;
            wr16_data = vecs[v].w16_data;
            wr8_en    = vecs[v].w8_en;
            wr8_sel   = vecs[v].w8_sel;
            wr8_data  = vecs[v].w8_data;
            flag_we   = vecs[v].fwe;
            flag_in   = vecs[v].fin;
            rd16_sel  = vecs[v].r16_sel;
            rd8_sel   = vecs[v].r8_sel;
            push_exp(vecs[v].exp_addr);
            push_exp(vecs[v].exp16);
            push_exp({8'h00, vecs[v].exp8});
            tick(1);
            check($sformatf("vec%0d_addr", v), addr);
            tick(3);
            clear_req();
            check($sformatf("vec%0d_rd16", v), rd16_data);
            check($sformatf("vec%0d_rd8", v), {8'h00, rd8_data});
        end

        // Stall at T2 for 5 clocks while a wr16 is pending
        wr16_en = 1'b1; wr16_sel = R16_HL; wr16_data = 16'h7777;
        rd16_sel = R16_HL;
        tick(2);
        cpu_en = 1'b0;
        tick(5);
        push_exp(16'd2); check("stall_tcycle", {14'd0, tcycle});
        push_exp(16'd0); check("stall_commit", {15'd0, commit});
        push_exp(16'h12AB); check("stall_hl", rd16_data);
        cpu_en = 1'b1;
        tick(1);
        push_exp(16'd1); check("resume_commit", {15'd0, commit});
        push_exp(BYPASS ? 16'h7777 : 16'h12AB); check("commit_hl_visibility", rd16_data);
        tick(1);
        clear_req();
        push_exp(16'h7777); check("stall_hl_written", rd16_data);
        push_exp(16'd0); check("stall_tcycle_wrap", {14'd0, tcycle});

        // cpu_en low during T3 suppresses commit
        wr8_en = 1'b1; wr8_sel = R8_A; wr8_data = 8'hC3;
        rd8_sel = R8_A;
        tick(3);
        cpu_en = 1'b0;
        #1;
        push_exp(16'd0); check("t3_hold_commit", {15'd0, commit});
        tick(2);
        push_exp(16'd3); check("t3_hold_tcycle", {14'd0, tcycle});
        push_exp(16'h005A); check("t3_hold_a", {8'h00, rd8_data});
        cpu_en = 1'b1;
        #1;
        push_exp(BYPASS ? 16'h00C3 : 16'h005A); check("bypass_a", {8'h00, rd8_data});
        tick(1);
        clear_req();
        push_exp(16'h00C3); check("a_written", {8'h00, rd8_data});

        // Address latch from AF (masked F) then held against a mid-cycle addr_sel change
        addr_sel = R16_AF;
        tick(1);
        push_exp(16'hC390); check("addr_af", addr);
        addr_sel = R16_WZ;
        tick(1);
        push_exp(16'hC390); check("addr_hold", addr);
        tick(3);
        push_exp(16'hBE11); check("addr_wz", addr);

        // Reset mid M-cycle drops the in-flight write
        tick(3);
        wr8_en = 1'b1; wr8_sel = R8_B; wr8_data = 8'h99;
        rd8_sel = R8_B; rd16_sel = R16_PC; addr_sel = R16_PC;
        tick(3);
        rst_n = 1'b0;
        #1;
        push_exp(16'd0); check("midrst_tcycle", {14'd0, tcycle});
        push_exp(16'd0); check("midrst_commit", {15'd0, commit});
        push_exp(16'h0000); check("midrst_addr", addr);
        tick(1);
        push_exp(16'h0000); check("midrst_b", {8'h00, rd8_data});
        rst_n = 1'b1;
        clear_req();
        tick(4);
        push_exp(16'h0000); check("postrst_b", {8'h00, rd8_data});
        push_exp(16'h0000); check("postrst_pc", rd16_data);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
